// File: rtl/pe_ctrl_pkg.sv
// Shared types and timing helpers for the PE datapath sequencers.
//   ctrl_state_e      : sequencer FSM states
//   drain_thr_t       : drain-counter values at which each stage enable rises, plus T_OUT
//   drain_thresholds(): derives drain_thr_t from the datapath stage latencies
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN
    } ctrl_state_e;

    typedef struct packed {
        int unsigned adder;
        int unsigned dequant;
        int unsigned bias;
        int unsigned act;
        int unsigned quant;
        int unsigned t_out;
    } drain_thr_t;

    // Each stage starts once the previous stage's result has had time to settle.
    // The extra +1 terms are the DSP output register and the bias-add stage.
    function automatic drain_thr_t drain_thresholds(input int unsigned dsp_lat,
                                                    input int unsigned adder_lat,
                                                    input int unsigned dequant_lat,
                                                    input int unsigned act_lat,
                                                    input int unsigned quant_lat);
        drain_thr_t t;
        t.adder   = dsp_lat + 1;
        t.dequant = t.adder + adder_lat;
        t.bias    = t.dequant + dequant_lat;
        t.act     = t.bias + 1;
        t.quant   = t.act + act_lat;
        t.t_out   = t.quant + quant_lat;
        return t;
    endfunction

endpackage

// File: rtl/pe_drain_sequencer.sv
// Drain-phase sequencer: counts cycles while active and raises the cumulative stage enables
// at their latency thresholds; done pulses on the final drain cycle.
//   clk, rst     : clock, synchronous active-high reset
//   active       : high while the owning controller is draining
//   adder_en ... quant_en : cumulative stage enables, low whenever active is low
//   done         : 1-cycle pulse at count == T_OUT
module pe_drain_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned pDSP_LATENCY     = 3,
    parameter int unsigned pADDER_LATENCY   = 1,
    parameter int unsigned pDEQUANT_LATENCY = 2,
    parameter int unsigned pACT_LATENCY     = 1,
    parameter int unsigned pQUANT_LATENCY   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic adder_en,
    output logic dequant_en,
    output logic bias_en,
    output logic act_en,
    output logic quant_en,
    output logic done
);
    localparam drain_thr_t Thr = drain_thresholds(pDSP_LATENCY, pADDER_LATENCY,
                                                  pDEQUANT_LATENCY, pACT_LATENCY,
                                                  pQUANT_LATENCY);
    localparam int unsigned CntW = $clog2(Thr.t_out + 1);

    localparam logic [CntW-1:0] AdderThr   = CntW'(Thr.adder);
    localparam logic [CntW-1:0] DequantThr = CntW'(Thr.dequant);
    localparam logic [CntW-1:0] BiasThr    = CntW'(Thr.bias);
    localparam logic [CntW-1:0] ActThr     = CntW'(Thr.act);
    localparam logic [CntW-1:0] QuantThr   = CntW'(Thr.quant);
    localparam logic [CntW-1:0] TOut       = CntW'(Thr.t_out);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter returns to 0 on the last drain cycle so a back-to-back drain starts clean.
    always_comb begin
        cnt_d = '0;
        if (active && (cnt_q != TOut)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign adder_en   = active && (cnt_q >= AdderThr);
    assign dequant_en = active && (cnt_q >= DequantThr);
    assign bias_en    = active && (cnt_q >= BiasThr);
    assign act_en     = active && (cnt_q >= ActThr);
    assign quant_en   = active && (cnt_q >= QuantThr);
    assign done       = active && (cnt_q == TOut);

endmodule

// File: rtl/pe_conv_mac_ctrl.sv
// Convolution MAC sequencer. Accepts the KK window taps of one output pixel per output-channel
// group, then drains the datapath and flags data_out valid; repeats for every group.
//   clk, rst                : clock, synchronous active-high reset
//   run                     : level, keep processing pixels while high
//   load_weight             : weight-load strobe, only monitored (err_load)
//   in_valid / in_ready     : upstream tap handshake
//   clr, en                 : accumulator clear, DSP enable (tap accept)
//   kernel_addr, bias_addr  : kernel RAM read address (one cycle ahead), bias address = group
//   adder_en ... quant_en   : cumulative stage enables during drain
//   grp_idx                 : current output-channel group
//   out_valid, pixel_done   : data_out valid pulse; also last group of the pixel
//   busy, err_load          : not idle; sticky load_weight-while-busy flag
module pe_conv_mac_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned pIN_CHANNEL      = 1,
    parameter int unsigned pOUT_CHANNEL     = 64,
    parameter int unsigned pOUTPUT_PARALLEL = 32,
    parameter int unsigned pKERNEL_SIZE     = 3,
    parameter int unsigned pKERNEL_NUM      = 1024,
    parameter int unsigned pBIAS_NUM        = 32,
    parameter int unsigned pDSP_LATENCY     = 3,
    parameter int unsigned pADDER_LATENCY   = 1,
    parameter int unsigned pDEQUANT_LATENCY = 2,
    parameter int unsigned pACT_LATENCY     = 1,
    parameter int unsigned pQUANT_LATENCY   = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          run,
    input  logic                                          load_weight,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic                                          clr,
    output logic                                          en,
    output logic [$clog2(pKERNEL_NUM)-1:0]                kernel_addr,
    output logic [$clog2(pBIAS_NUM)-1:0]                  bias_addr,
    output logic                                          adder_en,
    output logic                                          dequant_en,
    output logic                                          bias_en,
    output logic                                          act_en,
    output logic                                          quant_en,
    output logic [$clog2(pOUT_CHANNEL/pOUTPUT_PARALLEL):0] grp_idx,
    output logic                                          out_valid,
    output logic                                          pixel_done,
    output logic                                          busy,
    output logic                                          err_load
);
    localparam int unsigned NGRP     = pOUT_CHANNEL / pOUTPUT_PARALLEL;
    localparam int unsigned KK       = pKERNEL_SIZE * pKERNEL_SIZE;
    localparam int unsigned KAddrW   = $clog2(pKERNEL_NUM);
    localparam int unsigned BAddrW   = $clog2(pBIAS_NUM);
    localparam int unsigned GrpW     = $clog2(NGRP) + 1;
    localparam int unsigned TapW     = $clog2(KK + 1);
    localparam int unsigned AdderMin = (pIN_CHANNEL > 1) ? $clog2(pIN_CHANNEL) : 1;

    localparam logic [GrpW-1:0] LastGrp = GrpW'(NGRP - 1);
    localparam logic [TapW-1:0] LastTap = TapW'(KK - 1);

    if (NGRP == 0 || NGRP * pOUTPUT_PARALLEL != pOUT_CHANNEL) begin : g_bad_groups
        $error("pOUT_CHANNEL must be a non-zero multiple of pOUTPUT_PARALLEL");
    end
    if (pKERNEL_NUM < NGRP * KK || pBIAS_NUM < NGRP) begin : g_bad_depth
        $error("kernel/bias RAM too shallow for the group count");
    end
    if (pADDER_LATENCY < AdderMin) begin : g_bad_adder
        $error("pADDER_LATENCY too small for pIN_CHANNEL");
    end

    ctrl_state_e     state_q, state_d;
    logic [GrpW-1:0] grp_q, grp_d;
    logic [TapW-1:0] tap_q, tap_d;
    logic            err_q;

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        tap_d    = tap_q;
        in_ready = 1'b0;
        clr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = CLEAR;
            end
            CLEAR: begin
                clr     = 1'b1;
                state_d = MAC;
            end
            MAC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (tap_q == LastTap) begin
                        tap_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        tap_d = tap_q + TapW'(1);
                    end
                end
            end
            DRAIN: begin
                // run only matters between pixels; a started pixel always finishes all groups.
                if (out_valid) begin
                    if (grp_q == LastGrp) begin
                        grp_d   = '0;
                        state_d = run ? CLEAR : IDLE;
                    end else begin
                        grp_d   = grp_q + GrpW'(1);
                        state_d = CLEAR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            tap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            tap_q   <= tap_d;
            err_q   <= err_q | (load_weight & busy);
        end
    end

    pe_drain_sequencer #(
        .pDSP_LATENCY    (pDSP_LATENCY),
        .pADDER_LATENCY  (pADDER_LATENCY),
        .pDEQUANT_LATENCY(pDEQUANT_LATENCY),
        .pACT_LATENCY    (pACT_LATENCY),
        .pQUANT_LATENCY  (pQUANT_LATENCY)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
        .active    (state_q == DRAIN),
        .adder_en  (adder_en),
        .dequant_en(dequant_en),
        .bias_en   (bias_en),
        .act_en    (act_en),
        .quant_en  (quant_en),
        .done      (out_valid)
    );

    // Address is driven from the next tap count so the registered kernel RAM output lines up
    // with the tap being accepted in the following cycle.
    assign kernel_addr = KAddrW'(grp_q) * KAddrW'(KK) + KAddrW'(tap_d);
    assign bias_addr   = BAddrW'(grp_q);
    assign grp_idx     = grp_q;
    assign en          = in_valid & in_ready;
    assign pixel_done  = out_valid && (grp_q == LastGrp);
    assign busy        = (state_q != IDLE);
    assign err_load    = err_q;

endmodule

// File: tb/tb_pe_conv_mac_ctrl.sv
// Bench for pe_conv_mac_ctrl: default instance (two groups) and a single-group instance.
module tb_pe_conv_mac_ctrl;
    localparam int KK = 9;

    typedef struct {
        bit sel;        // 0: two-group DUT, 1: single-group DUT
        int run_taps;   // drop run once this many taps have been accepted
        int stall_a;    // tap index after which in_valid drops (-1: none)
        int stall_b;
        int stall_len;
        int exp_ov;     // out_valid pulses expected
        int first_ov;   // cycles from run rising to first out_valid
        int period;     // cycles between consecutive out_valid pulses
    } vec_t;

    typedef struct {
        int cyc;
        int grp;
        int done;
    } exp_t;

    logic clk = 1'b0;
    logic rst, run0, run1, in_valid, load_weight;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   sel = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rdy_w[2], clr_w[2], en_w[2], adder_w[2], deq_w[2], bias_w[2], act_w[2];
    logic       quant_w[2], ov_w[2], pd_w[2], busy_w[2], err_w[2];
    logic [9:0] kaddr_w[2];
    logic [4:0] baddr_w[2];
    logic [1:0] grp0_w;
    logic [0:0] grp1_w;

    pe_conv_mac_ctrl dut0 (
        .clk(clk), .rst(rst), .run(run0), .load_weight(load_weight), .in_valid(in_valid),
        .in_ready(rdy_w[0]), .clr(clr_w[0]), .en(en_w[0]), .kernel_addr(kaddr_w[0]),
        .bias_addr(baddr_w[0]), .adder_en(adder_w[0]), .dequant_en(deq_w[0]),
        .bias_en(bias_w[0]), .act_en(act_w[0]), .quant_en(quant_w[0]), .grp_idx(grp0_w),
        .out_valid(ov_w[0]), .pixel_done(pd_w[0]), .busy(busy_w[0]), .err_load(err_w[0])
    );

    pe_conv_mac_ctrl #(.pOUT_CHANNEL(32)) dut1 (
        .clk(clk), .rst(rst), .run(run1), .load_weight(load_weight), .in_valid(in_valid),
        .in_ready(rdy_w[1]), .clr(clr_w[1]), .en(en_w[1]), .kernel_addr(kaddr_w[1]),
        .bias_addr(baddr_w[1]), .adder_en(adder_w[1]), .dequant_en(deq_w[1]),
        .bias_en(bias_w[1]), .act_en(act_w[1]), .quant_en(quant_w[1]), .grp_idx(grp1_w),
        .out_valid(ov_w[1]), .pixel_done(pd_w[1]), .busy(busy_w[1]), .err_load(err_w[1])
    );

    logic       c_rdy, c_clr, c_en, c_ov, c_pd, c_busy, c_err;
    logic [4:0] c_stage;  // bit 0 adder .. bit 4 quant
    logic [9:0] c_kaddr;
    logic [4:0] c_baddr;
    logic [1:0] c_grp;

    always_comb begin
        c_rdy   = rdy_w[sel];
        c_clr   = clr_w[sel];
        c_en    = en_w[sel];
        c_ov    = ov_w[sel];
        c_pd    = pd_w[sel];
        c_busy  = busy_w[sel];
        c_err   = err_w[sel];
        c_stage = {quant_w[sel], act_w[sel], bias_w[sel], deq_w[sel], adder_w[sel]};
        c_kaddr = kaddr_w[sel];
        c_baddr = baddr_w[sel];
        c_grp   = sel ? {1'b0, grp1_w} : grp0_w;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_run(input bit v);
        if (sel) run1 = v;
        else run0 = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; run0 = 1'b0; run1 = 1'b0; load_weight = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, int'({c_rdy, c_clr, c_en, c_stage, c_ov, c_pd, c_busy, c_err}), 0);
        chk({name, "_kaddr"}, int'(c_kaddr), 0);
        chk({name, "_baddr"}, int'(c_baddr), 0);
        chk({name, "_grp"}, int'(c_grp), 0);
    endtask

    // Streams taps until the expected out_valid pulses are seen; expectations come from the
    // accept cycle of each group's last tap plus the fixed drain length.
    task automatic run_vec(input int idx, input vec_t v);
        int         taps = 0, stall = 0, c0 = 0, guard = 0, tail = 0, en_cnt = 0;
        int         ngrp, grp_m, tap_m;
        int         rise[5];
        int         offs[5] = '{6, 5, 3, 2, 1};
        int         ov_log[$];
        logic [4:0] st_prev = '0;
        logic       ov_prev = 1'b0;
        logic [9:0] prev_kaddr;
        bit         missed;
        exp_t       e;
        sel  = v.sel;
        ngrp = v.sel ? 1 : 2;
        exp_q.delete();
        foreach (rise[i]) rise[i] = -1;
        next_cycle();
        set_run(1'b1);
        in_valid = 1'b1;
        #1;
        c0 = cyc;
        prev_kaddr = c_kaddr;
        while (guard < 400 && !(ov_log.size() >= v.exp_ov && tail >= 3)) begin
            next_cycle();
            if (taps >= v.run_taps) set_run(1'b0);
            in_valid = (stall == 0);
            if (stall > 0) stall--;
            #1;
            guard++;
            if (in_valid && c_rdy) begin
                grp_m = (taps / KK) % ngrp;
                tap_m = taps % KK;
                chk("kernel_addr", int'(prev_kaddr), grp_m * KK + tap_m);
                chk("grp_idx", int'(c_grp), grp_m);
                chk("bias_addr", int'(c_baddr), grp_m);
                if (tap_m == KK - 1) begin
                    e.cyc  = cyc + 11;
                    e.grp  = grp_m;
                    e.done = int'(grp_m == ngrp - 1);
                    exp_q.push_back(e);
                end
                if (v.stall_len > 0 && (tap_m == v.stall_a || tap_m == v.stall_b))
                    stall = v.stall_len;
                taps++;
            end
            chk("en_gated", int'(c_en && !in_valid), 0);
            if (c_en) en_cnt++;
            for (int i = 0; i < 5; i++) if (c_stage[i] && !st_prev[i]) rise[i] = cyc;
            chk("pixel_done_alone", int'(c_pd && !c_ov), 0);
            chk("stray_out_valid", int'(c_ov && exp_q.size() == 0), 0);
            if (ov_prev) chk("stage_fall", int'(c_stage), 0);
            if (c_ov && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ov_cycle", cyc, e.cyc);
                chk("ov_grp", int'(c_grp), e.grp);
                chk("pixel_done", int'(c_pd), e.done);
                chk("ov_bias", int'(c_baddr), e.grp);
                chk("en_count", en_cnt, KK);
                en_cnt = 0;
                for (int i = 0; i < 5; i++)
                    chk($sformatf("stage%0d_rise", i), rise[i], cyc - offs[i]);
                ov_log.push_back(cyc);
            end
            missed = 1'b0;
            if (exp_q.size() > 0) if (exp_q[0].cyc < cyc) missed = 1'b1;
            chk("missed_out_valid", int'(missed), 0);
            if (missed) void'(exp_q.pop_front());
            st_prev    = c_stage;
            ov_prev    = c_ov;
            prev_kaddr = c_kaddr;
            if (ov_log.size() >= v.exp_ov) tail++;
        end
        chk($sformatf("vec%0d_ov_count", idx), ov_log.size(), v.exp_ov);
        if (ov_log.size() > 0) chk($sformatf("vec%0d_first_ov", idx), ov_log[0] - c0, v.first_ov);
        for (int i = 1; i < ov_log.size(); i++)
            chk($sformatf("vec%0d_period", idx), ov_log[i] - ov_log[i-1], v.period);
        chk($sformatf("vec%0d_idle_busy", idx), int'(c_busy), 0);
        chk($sformatf("vec%0d_idle_ready", idx), int'(c_rdy), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, ovc;
        rst = 1'b1; run0 = 1'b0; run1 = 1'b0; in_valid = 1'b1; load_weight = 1'b0;
        //          sel  run_taps stall_a stall_b len exp_ov first period
        vecs[0] = '{1'b0, 36,     -1,     -1,     0,  4,     21,   21};  // two pixels
        vecs[1] = '{1'b0, 18,      3,      7,     2,  2,     25,   25};  // tap stalls
        vecs[2] = '{1'b0,  3,     -1,     -1,     0,  2,     21,   21};  // run drops in grp0
        vecs[3] = '{1'b1, 18,     -1,     -1,     0,  2,     21,   21};  // single group
        vecs[4] = '{1'b0, 18,      0,      8,     1,  2,     22,   22};  // stall after first/last

        // Reset state of both instances, with in_valid held high.
        do_reset();
        #1;
        chk_all_zero("reset0");
        sel = 1'b1;
        #1;
        chk_all_zero("reset1");
        sel = 1'b0;

        // load_weight in IDLE is harmless; while busy it sets a sticky flag.
        next_cycle(); load_weight = 1'b1; #1;
        next_cycle(); load_weight = 1'b0; #1;
        chk("err_idle", int'(c_err), 0);
        set_run(1'b1);
        repeat (3) next_cycle();
        load_weight = 1'b1;
        set_run(1'b0);
        #1;
        chk("busy_at_strobe", int'(c_busy), 1);
        next_cycle(); load_weight = 1'b0; #1;
        chk("err_set", int'(c_err), 1);
        g = 0;
        while (c_busy && g < 100) begin
            next_cycle(); #1; g++;
        end
        chk("err_drain_done", int'(c_busy), 0);
        chk("err_sticky", int'(c_err), 1);
        do_reset();
        #1;
        chk("err_cleared", int'(c_err), 0);

        // Reset at DRAIN d=5 of group 1 aborts without out_valid.
        next_cycle(); set_run(1'b1); #1;
        for (int k = 1; k <= 37; k++) begin
            next_cycle(); #1;
            if (k == 21) begin
                chk("s4_ov_grp0", int'(c_ov), 1);
                chk("s4_ov_grp0_idx", int'(c_grp), 0);
            end
            if (k == 36) chk("s4_stage_d4", int'(c_stage), 1);
            if (k == 37) begin
                chk("s4_stage_d5", int'(c_stage), 3);
                chk("s4_bias_grp1", int'(c_baddr), 1);
            end
        end
        rst = 1'b1;
        set_run(1'b0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk_all_zero("s4_rst");
        ovc = 0;
        repeat (15) begin
            next_cycle(); #1;
            if (c_ov) ovc++;
        end
        chk("s4_no_ov", ovc, 0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
